// File: rtl/bus_pkg.sv
// Shared types and defaults for the cpu4510 bus controller: device select,
// wait-state FSM encoding and the address decode helper.
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_MEM = 2'd0,
    BUS_IO  = 2'd1,
    BUS_HYP = 2'd2
  } bus_dev_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } bus_st_e;

  localparam logic [19:0] IO_ADDR_DEF  = 20'h0BFFC;
  localparam logic [13:0] HYP_BASE_DEF = 14'h0359;

  // IO wins over the hyper_ctrl window, which wins over RAM.
  function automatic bus_dev_e bus_decode(input logic [19:0] addr,
                                          input logic [19:0] io_addr,
                                          input logic [13:0] hyp_base);
    bus_dev_e dev;
    dev = BUS_MEM;
    if (addr == io_addr)
      dev = BUS_IO;
    else if (addr[19:6] == hyp_base)
      dev = BUS_HYP;
    return dev;
  endfunction

endpackage

// File: rtl/bus_wait_gen.sv
// Wait-state generator: holds CPU ready low for the decoded device's wait
// count, then releases it unless the mapper is stalling.
module bus_wait_gen
  import bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] wait_i,
  input  logic       mapper_busy_i,
  output logic       ready_o
);

  bus_st_e    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wait_i == 4'd0) begin
          rdy = ~mapper_busy_i;
        end else begin
          cnt_d   = wait_i - 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // mapper_busy only masks ready; the count keeps running underneath it
        rdy = (cnt_q == 4'd0) & ~mapper_busy_i;
        if (cnt_q != 4'd0)
          cnt_d = cnt_q - 4'd1;
        if (rdy)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_o = rdy & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// cpu4510 bus controller: decodes the next-cycle address, inserts per-device
// wait states, strobes RAM writes, owns the irq/nmi I/O port, muxes read data.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter logic [3:0]  MEM_WAIT = 4'd0,
  parameter logic [3:0]  IO_WAIT  = 4'd1,
  parameter logic [3:0]  HYP_WAIT = 4'd0,
  parameter logic [19:0] IO_ADDR  = IO_ADDR_DEF,
  parameter logic [13:0] HYP_BASE = HYP_BASE_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address_next,
  input  logic        write_next,
  input  logic [7:0]  data_o_next,
  input  logic        mapper_busy,
  input  logic [7:0]  mem_data_i,
  input  logic [7:0]  hyper_data_i,
  output logic        ready,
  output logic [7:0]  data_i,
  output logic        mem_we,
  output logic        hyper_cs,
  output logic        io_cs,
  output logic [7:0]  io_port,
  output logic        irq,
  output logic        nmi
);

  bus_dev_e   dev_d, dev_q;
  logic [3:0] wait_sel;
  logic       rdy;
  logic [7:0] io_port_q, io_port_d;

  always_comb begin
    dev_d    = bus_decode(address_next, IO_ADDR, HYP_BASE);
    io_cs    = (dev_d == BUS_IO);
    hyper_cs = (dev_d == BUS_HYP);
    case (dev_d)
      BUS_IO:  wait_sel = IO_WAIT;
      BUS_HYP: wait_sel = HYP_WAIT;
      default: wait_sel = MEM_WAIT;
    endcase
  end

  bus_wait_gen u_wait (
    .clk           (clk),
    .reset         (reset),
    .wait_i        (wait_sel),
    .mapper_busy_i (mapper_busy),
    .ready_o       (rdy)
  );

  assign ready  = rdy;
  assign mem_we = write_next & rdy & ~io_cs & ~hyper_cs;

  always_comb begin
    io_port_d = io_port_q;
    if (io_cs & write_next & rdy)
      io_port_d = data_o_next;
  end

  // dev_q remembers which slave owns the data coming back this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      io_port_q <= 8'h00;
      dev_q     <= BUS_MEM;
    end else begin
      io_port_q <= io_port_d;
      dev_q     <= dev_d;
    end
  end

  always_comb begin
    case (dev_q)
      BUS_IO:  data_i = io_port_q;
      BUS_HYP: data_i = hyper_data_i;
      default: data_i = mem_data_i;
    endcase
  end

  assign io_port = io_port_q;
  assign irq     = io_port_q[0];
  assign nmi     = io_port_q[1];

endmodule
